// File: rtl/elevator_scheduler_if.sv
// Purpose : call/sensor inputs and motor/door/status outputs of the elevator scheduler.
// Latency : plain wires, no storage.
// Backpressure: none; calls are level signals that the scheduler latches.
// Ports   : cab_req/hall_up/hall_dn/floor_sensor/door_hold toward the controller;
//           ac/display/door_open/busy/fault back from it.
interface elevator_scheduler_if #(
   parameter int N_FLOORS = 3,
   parameter int FLOOR_W  = 2
);
   logic [N_FLOORS-1:0] cab_req;
   logic [N_FLOORS-1:0] hall_up;
   logic [N_FLOORS-1:0] hall_dn;
   logic [N_FLOORS-1:0] floor_sensor;
   logic                door_hold;
   logic [1:0]          ac;
   logic [FLOOR_W-1:0]  display;
   logic                door_open;
   logic                busy;
   logic                fault;

   // controller side
   modport slave (
      input  cab_req, hall_up, hall_dn, floor_sensor, door_hold,
      output ac, display, door_open, busy, fault
   );

   // building / stimulus side
   modport master (
      output cab_req, hall_up, hall_dn, floor_sensor, door_hold,
      input  ac, display, door_open, busy, fault
   );
endinterface

// File: rtl/elevator_scheduler.sv
// Purpose : single-car SCAN elevator controller with door timer and movement watchdog.
// Latency : a call latched at edge k is acted on at edge k+1; all outputs are registered state.
// Backpressure: none; calls are held in pending registers until served.
// Ports   : clk, rst_n (synchronous, active low); bus = elevator_scheduler_if.slave
//           (cab/hall calls, one-hot floor sensors, door_hold in; ac, display, door_open, busy, fault out).
module elevator_scheduler #(
   parameter int N_FLOORS     = 3,
   parameter int FLOOR_W      = 2,
   parameter int DOOR_CYCLES  = 8,
   parameter int MOVE_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   elevator_scheduler_if.slave  bus
);
   localparam int CNT_W = $clog2(DOOR_CYCLES + 1);
   localparam int WD_W  = $clog2(MOVE_TIMEOUT + 1);
   // top floor has no up button, ground floor has no down button
   localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
   localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR, S_FAULT} state_t;

   state_t              state_q, state_d;
   logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
   logic                dir_up_q, dir_up_d;
   logic [N_FLOORS-1:0] pend_cab_q, pend_cab_d;
   logic [N_FLOORS-1:0] pend_up_q, pend_up_d;
   logic [N_FLOORS-1:0] pend_dn_q, pend_dn_d;
   logic [CNT_W-1:0]    door_cnt_q, door_cnt_d;
   logic [WD_W-1:0]     wdog_q, wdog_d;

   logic [N_FLOORS-1:0] pend_all, cab_in, up_in, dn_in, here_mask;
   logic [N_FLOORS-1:0] clr_cab, clr_up, clr_dn, door_mask;
   logic [FLOOR_W-1:0]  hit_idx, door_floor;
   logic                enter_door, door_dir_up, beyond;

   function automatic logic any_above(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < N_FLOORS; i++)
         if (i > int'(f)) r = r | v[i];
      return r;
   endfunction

   function automatic logic any_below(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < N_FLOORS; i++)
         if (i < int'(f)) r = r | v[i];
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      cur_floor_d = cur_floor_q;
      dir_up_d    = dir_up_q;
      door_cnt_d  = door_cnt_q;
      wdog_d      = wdog_q;
      clr_cab     = '0;
      clr_up      = '0;
      clr_dn      = '0;
      door_mask   = '0;
      enter_door  = 1'b0;
      door_floor  = cur_floor_q;
      door_dir_up = dir_up_q;
      beyond      = 1'b0;
      hit_idx     = '0;

      pend_all  = pend_cab_q | pend_up_q | pend_dn_q;
      here_mask = N_FLOORS'(1) << cur_floor_q;

      // Calls at the open-door floor are served by the open door, so never latch them.
      cab_in = bus.cab_req;
      up_in  = bus.hall_up & UP_MASK;
      dn_in  = bus.hall_dn & DN_MASK;
      if (state_q == S_DOOR) begin
         cab_in = cab_in & ~here_mask;
         up_in  = up_in  & ~here_mask;
         dn_in  = dn_in  & ~here_mask;
      end

      for (int i = 0; i < N_FLOORS; i++)
         if (bus.floor_sensor[i]) hit_idx = FLOOR_W'(i);

      case (state_q)
         S_IDLE: begin
            if (pend_all[cur_floor_q]) begin
               enter_door = 1'b1;
            end else if (any_above(pend_all, cur_floor_q) &&
                         (dir_up_q || !any_below(pend_all, cur_floor_q))) begin
               state_d  = S_MOVE_UP;
               dir_up_d = 1'b1;
               wdog_d   = '0;
            end else if (any_below(pend_all, cur_floor_q)) begin
               state_d  = S_MOVE_DN;
               dir_up_d = 1'b0;
               wdog_d   = '0;
            end
         end
         S_MOVE_UP, S_MOVE_DN: begin
            if (bus.floor_sensor == '0) begin
               wdog_d = wdog_q + 1'b1;
               if (wdog_d == WD_W'(MOVE_TIMEOUT)) state_d = S_FAULT;
            end else if (!$onehot(bus.floor_sensor) ||
                         ((state_q == S_MOVE_UP) && (hit_idx != cur_floor_q + 1'b1)) ||
                         ((state_q == S_MOVE_DN) && (hit_idx + 1'b1 != cur_floor_q))) begin
               // skipped floor, wrong direction or multi-hot sensor
               state_d = S_FAULT;
            end else begin
               cur_floor_d = hit_idx;
               wdog_d      = '0;
               door_floor  = hit_idx;
               if (state_q == S_MOVE_UP) begin
                  door_dir_up = 1'b1;
                  enter_door  = pend_cab_q[hit_idx] || pend_up_q[hit_idx] ||
                                !any_above(pend_all, hit_idx) ||
                                (hit_idx == FLOOR_W'(N_FLOORS-1));
               end else begin
                  door_dir_up = 1'b0;
                  enter_door  = pend_cab_q[hit_idx] || pend_dn_q[hit_idx] ||
                                !any_below(pend_all, hit_idx) || (hit_idx == '0);
               end
            end
         end
         S_DOOR: begin
            if (bus.door_hold) begin
               door_cnt_d = CNT_W'(DOOR_CYCLES-1);
            end else if (door_cnt_q != '0) begin
               door_cnt_d = door_cnt_q - 1'b1;
            end else begin
               // keep sweeping the same way if possible, else reverse, else rest
               wdog_d = '0;
               if (dir_up_q ? any_above(pend_all, cur_floor_q) : any_below(pend_all, cur_floor_q)) begin
                  state_d = dir_up_q ? S_MOVE_UP : S_MOVE_DN;
               end else if (dir_up_q ? any_below(pend_all, cur_floor_q) : any_above(pend_all, cur_floor_q)) begin
                  state_d  = dir_up_q ? S_MOVE_DN : S_MOVE_UP;
                  dir_up_d = !dir_up_q;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase

      if (enter_door) begin
         state_d    = S_DOOR;
         door_cnt_d = CNT_W'(DOOR_CYCLES-1);
         door_mask  = N_FLOORS'(1) << door_floor;
         clr_cab    = door_mask;
         if (door_dir_up) clr_up = door_mask;
         else             clr_dn = door_mask;
         // nobody left ahead: the car will reverse or rest, so both hall calls are served
         beyond = door_dir_up ? any_above(pend_all, door_floor) : any_below(pend_all, door_floor);
         if (!beyond) begin
            clr_up = door_mask;
            clr_dn = door_mask;
         end
      end

      // clear beats a same-edge set
      pend_cab_d = (pend_cab_q | cab_in) & ~clr_cab;
      pend_up_d  = (pend_up_q  | up_in)  & ~clr_up;
      pend_dn_d  = (pend_dn_q  | dn_in)  & ~clr_dn;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cur_floor_q <= '0;
         dir_up_q    <= 1'b1;
         pend_cab_q  <= '0;
         pend_up_q   <= '0;
         pend_dn_q   <= '0;
         door_cnt_q  <= '0;
         wdog_q      <= '0;
      end else begin
         state_q     <= state_d;
         cur_floor_q <= cur_floor_d;
         dir_up_q    <= dir_up_d;
         pend_cab_q  <= pend_cab_d;
         pend_up_q   <= pend_up_d;
         pend_dn_q   <= pend_dn_d;
         door_cnt_q  <= door_cnt_d;
         wdog_q      <= wdog_d;
      end
   end

   assign bus.ac        = (state_q == S_MOVE_UP) ? 2'b10 :
                          (state_q == S_MOVE_DN) ? 2'b01 : 2'b00;
   assign bus.display   = cur_floor_q + 1'b1;
   assign bus.door_open = (state_q == S_DOOR);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.fault     = (state_q == S_FAULT);
endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   elevator_scheduler_if #(.N_FLOORS(3), .FLOOR_W(2)) bus_if();

   elevator_scheduler #(
      .N_FLOORS(3), .FLOOR_W(2), .DOOR_CYCLES(8), .MOVE_TIMEOUT(64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_inputs;
      bus_if.cab_req      = '0;
      bus_if.hall_up      = '0;
      bus_if.hall_dn      = '0;
      bus_if.floor_sensor = '0;
      bus_if.door_hold    = 1'b0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      clear_inputs();
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (bus_if.ac !== 2'b00) begin failures++; $display("FAIL reset_ac got=%b exp=00", bus_if.ac); end
      checks++; if (bus_if.display !== 2'd1) begin failures++; $display("FAIL reset_display got=%0d exp=1", bus_if.display); end
      checks++; if (bus_if.door_open !== 1'b0) begin failures++; $display("FAIL reset_door got=%b exp=0", bus_if.door_open); end
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
      checks++; if (bus_if.fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", bus_if.fault); end
   endtask

   // cab call to the top floor: pass floor 2 without stopping, stop and open at floor 3
   task automatic test_cab_to_top;
      do_reset();
      bus_if.cab_req = 3'b100; tick(1); bus_if.cab_req = 3'b000;
      checks++; if (bus_if.ac !== 2'b00) begin failures++; $display("FAIL top_latch_ac got=%b exp=00", bus_if.ac); end
      tick(1);
      checks++; if (bus_if.ac !== 2'b10) begin failures++; $display("FAIL top_move_ac got=%b exp=10", bus_if.ac); end
      checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL top_busy got=%b exp=1", bus_if.busy); end
      bus_if.floor_sensor = 3'b010; tick(1); bus_if.floor_sensor = 3'b000;
      checks++; if (bus_if.ac !== 2'b10) begin failures++; $display("FAIL top_pass_ac got=%b exp=10", bus_if.ac); end
      checks++; if (bus_if.display !== 2'd2) begin failures++; $display("FAIL top_pass_disp got=%0d exp=2", bus_if.display); end
      tick(2);
      bus_if.floor_sensor = 3'b100; tick(1); bus_if.floor_sensor = 3'b000;
      checks++; if (bus_if.ac !== 2'b00) begin failures++; $display("FAIL top_stop_ac got=%b exp=00", bus_if.ac); end
      checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL top_door got=%b exp=1", bus_if.door_open); end
      checks++; if (bus_if.display !== 2'd3) begin failures++; $display("FAIL top_disp got=%0d exp=3", bus_if.display); end
      tick(7);
      checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL top_door_last got=%b exp=1", bus_if.door_open); end
      tick(1);
      checks++; if (bus_if.door_open !== 1'b0) begin failures++; $display("FAIL top_door_closed got=%b exp=0", bus_if.door_open); end
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL top_idle_busy got=%b exp=0", bus_if.busy); end
   endtask

   // hall call at the current floor opens the door without motion; ignored buttons do nothing
   task automatic test_hall_here;
      do_reset();
      bus_if.hall_up = 3'b001; tick(1); bus_if.hall_up = 3'b000;
      checks++; if (bus_if.door_open !== 1'b0) begin failures++; $display("FAIL here_latch_door got=%b exp=0", bus_if.door_open); end
      tick(1);
      checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL here_door got=%b exp=1", bus_if.door_open); end
      checks++; if (bus_if.ac !== 2'b00) begin failures++; $display("FAIL here_ac got=%b exp=00", bus_if.ac); end
      tick(7);
      checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL here_door_last got=%b exp=1", bus_if.door_open); end
      tick(1);
      checks++; if (bus_if.door_open !== 1'b0) begin failures++; $display("FAIL here_door_closed got=%b exp=0", bus_if.door_open); end
      checks++; if (dut.pend_up_q !== 3'b000) begin failures++; $display("FAIL here_pend_up got=%b exp=000", dut.pend_up_q); end
      bus_if.hall_up = 3'b100; bus_if.hall_dn = 3'b001; tick(1);
      bus_if.hall_up = 3'b000; bus_if.hall_dn = 3'b000;
      tick(3);
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL ignored_buttons_busy got=%b exp=0", bus_if.busy); end
   endtask

   // hold at counter 2 restarts the full open time; calls at this floor are absorbed
   task automatic test_door_hold;
      do_reset();
      bus_if.cab_req = 3'b001; tick(1); bus_if.cab_req = 3'b000;
      tick(1);
      tick(5);
      checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL hold_pre got=%b exp=1", bus_if.door_open); end
      bus_if.door_hold = 1'b1; bus_if.cab_req = 3'b001; tick(1);
      bus_if.door_hold = 1'b0; bus_if.cab_req = 3'b000;
      tick(7);
      checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL hold_extended got=%b exp=1", bus_if.door_open); end
      tick(1);
      checks++; if (bus_if.door_open !== 1'b0) begin failures++; $display("FAIL hold_closed got=%b exp=0", bus_if.door_open); end
      tick(2);
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL hold_absorbed_busy got=%b exp=0", bus_if.busy); end
   endtask

   // stop for hall_up at floor 2, continue to 3, then reverse down serving 2 and 1
   task automatic test_sweep;
      do_reset();
      bus_if.cab_req = 3'b100; bus_if.hall_up = 3'b010; tick(1);
      bus_if.cab_req = 3'b000; bus_if.hall_up = 3'b000;
      tick(1);
      checks++; if (bus_if.ac !== 2'b10) begin failures++; $display("FAIL sweep_up_ac got=%b exp=10", bus_if.ac); end
      bus_if.floor_sensor = 3'b010; tick(1); bus_if.floor_sensor = 3'b000;
      checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL sweep_stop2_door got=%b exp=1", bus_if.door_open); end
      checks++; if (bus_if.display !== 2'd2) begin failures++; $display("FAIL sweep_stop2_disp got=%0d exp=2", bus_if.display); end
      tick(8);
      checks++; if (bus_if.ac !== 2'b10) begin failures++; $display("FAIL sweep_continue_ac got=%b exp=10", bus_if.ac); end
      bus_if.floor_sensor = 3'b100; tick(1); bus_if.floor_sensor = 3'b000;
      checks++; if (bus_if.display !== 2'd3) begin failures++; $display("FAIL sweep_top_disp got=%0d exp=3", bus_if.display); end
      bus_if.hall_dn = 3'b010; bus_if.cab_req = 3'b001; tick(1);
      bus_if.hall_dn = 3'b000; bus_if.cab_req = 3'b000;
      tick(6);
      checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL sweep_top_door got=%b exp=1", bus_if.door_open); end
      tick(1);
      checks++; if (bus_if.ac !== 2'b01) begin failures++; $display("FAIL sweep_down_ac got=%b exp=01", bus_if.ac); end
      bus_if.floor_sensor = 3'b010; tick(1); bus_if.floor_sensor = 3'b000;
      checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL sweep_dn_stop2_door got=%b exp=1", bus_if.door_open); end
      checks++; if (dut.pend_dn_q[1] !== 1'b0) begin failures++; $display("FAIL sweep_hall_dn1_cleared got=%b exp=0", dut.pend_dn_q[1]); end
      tick(8);
      checks++; if (bus_if.ac !== 2'b01) begin failures++; $display("FAIL sweep_down2_ac got=%b exp=01", bus_if.ac); end
      bus_if.floor_sensor = 3'b001; tick(1); bus_if.floor_sensor = 3'b000;
      checks++; if (bus_if.display !== 2'd1) begin failures++; $display("FAIL sweep_ground_disp got=%0d exp=1", bus_if.display); end
      tick(8);
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL sweep_end_busy got=%b exp=0", bus_if.busy); end
   endtask

   task automatic test_watchdog;
      int n;
      do_reset();
      bus_if.cab_req = 3'b100; tick(1); bus_if.cab_req = 3'b000;
      tick(1);
      tick(60);
      checks++; if (bus_if.fault !== 1'b0) begin failures++; $display("FAIL wdog_early got=%b exp=0", bus_if.fault); end
      n = 0;
      while (bus_if.fault !== 1'b1 && n < 10) begin
         tick(1);
         n++;
      end
      checks++; if (bus_if.fault !== 1'b1) begin failures++; $display("FAIL wdog_fault got=%b exp=1", bus_if.fault); end
      checks++; if (bus_if.ac !== 2'b00) begin failures++; $display("FAIL wdog_ac got=%b exp=00", bus_if.ac); end
      checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL wdog_busy got=%b exp=1", bus_if.busy); end
      rst_n = 1'b0; tick(1);
      checks++; if (bus_if.fault !== 1'b0) begin failures++; $display("FAIL wdog_rst_fault got=%b exp=0", bus_if.fault); end
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL wdog_rst_busy got=%b exp=0", bus_if.busy); end
      checks++; if (bus_if.display !== 2'd1) begin failures++; $display("FAIL wdog_rst_disp got=%0d exp=1", bus_if.display); end
      rst_n = 1'b1;
   endtask

   task automatic test_sensor_fault;
      do_reset();
      bus_if.cab_req = 3'b100; tick(1); bus_if.cab_req = 3'b000;
      tick(1);
      bus_if.floor_sensor = 3'b011; tick(1); bus_if.floor_sensor = 3'b000;
      checks++; if (bus_if.fault !== 1'b1) begin failures++; $display("FAIL multihot_fault got=%b exp=1", bus_if.fault); end
      checks++; if (bus_if.ac !== 2'b00) begin failures++; $display("FAIL multihot_ac got=%b exp=00", bus_if.ac); end
      bus_if.cab_req = 3'b001; tick(3); bus_if.cab_req = 3'b000;
      checks++; if (bus_if.fault !== 1'b1) begin failures++; $display("FAIL fault_latched got=%b exp=1", bus_if.fault); end
      do_reset();
      bus_if.cab_req = 3'b100; tick(1); bus_if.cab_req = 3'b000;
      tick(1);
      bus_if.floor_sensor = 3'b100; tick(1); bus_if.floor_sensor = 3'b000;
      checks++; if (bus_if.fault !== 1'b1) begin failures++; $display("FAIL skip_fault got=%b exp=1", bus_if.fault); end
      checks++; if (bus_if.display !== 2'd1) begin failures++; $display("FAIL skip_disp got=%0d exp=1", bus_if.display); end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_cab_to_top();
      test_hall_here();
      test_door_hold();
      test_sweep();
      test_watchdog();
      test_sensor_fault();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
